control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Registered multicycle control-state sequencer for the MIPS datapath.
- Holds the current control state and steps fetch, memory-wait, decode and execute sequences.
- Dispatches on the instruction word through a parametrised decode sub-module.
- Sequences the memory handshake using MOC (mem_done).
- Adds wait-state timeout, stall freeze and sticky traps for illegal instructions and memory timeout.

Parameters:
- STATE_W, 7, width of state_sel and all state codes.
- IR_W, 32, instruction width; decode uses bits [IR_W-1:IR_W-6] as opcode and [5:0] as funct.
- MEM_TIMEOUT, 15, maximum wait cycles without mem_done before trap; 0 disables the timeout.
- WAIT_W, 4, wait counter width; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  IR_W  instruction register contents, valid from S_DECODE onward.
- mem_done  in  1  memory operation complete (MOC).
- cond_true  in  1  branch condition from ALU flags, sampled in S_BR_EVAL.
- stall  in  1  freeze the state and the wait counter.
- trap_clear  in  1  leave a trap state.
- state_sel  out  STATE_W  current state code.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- ir_load  out  1  load the instruction register.
- pc_inc  out  1  increment the PC.
- illegal_trap  out  1  high while in S_ILLEGAL.
- timeout_trap  out  1  high while in S_TIMEOUT.

Behaviour:
- Reset (async, rst_n=0):
  - State becomes S_RESET=0 and the wait counter becomes 0.
  - All outputs are 0 immediately.
- State register:
  - Updates on the rising clk edge.
  - Outputs are pure Moore decodes of the state register; there is no combinational path from any input to any output.
- Fetch sequence:
  - S_RESET -> S_FETCH (1).
  - S_FETCH -> S_FETCH_WAIT (2).
  - S_FETCH_WAIT -> S_IR_LOAD (3) when mem_done=1.
  - S_IR_LOAD -> S_DECODE (4).
- Output decode per state:
  - mem_req=1 in S_FETCH, S_FETCH_WAIT, S_LD_WAIT and S_ST_WAIT.
  - mem_we=1 only in S_ST_WAIT.
  - ir_load=1 and pc_inc=1 only in S_IR_LOAD.
- S_DECODE dispatches to the code returned by instr_dispatch:
  - ALU ops: ADDU 6, SUBU 17, ADDIU 18, SLTU 19, SLTIU 20, CLO 21, CLZ 22, AND 23, ANDI 24, OR 25, ORI 26, XOR 27, XORI 28, NOR 29, LUI 30, SLL 31, SRA 32, SRL 33, MOVN 34, MOVZ 35.
  - Store (SB/SH/SW) -> S_ST_ADDR 7.
  - Load (LW/LH/LHU/LB/LBU) -> S_LD_ADDR 13.
  - BEQ -> S_BR_EVAL 11; BNE 41; BGEZ 37; BGTZ 39; BLEZ 42.
  - No match -> S_ILLEGAL 126.
- Execute sequences (every path ends back at S_FETCH):
  - ALU: any ALU exec state -> S_ALU_WB (5) -> S_FETCH.
  - Store: S_ST_ADDR -> S_ST_WAIT (8); S_ST_WAIT -> S_FETCH on mem_done.
  - Load: S_LD_ADDR -> S_LD_WAIT (14); S_LD_WAIT -> S_LD_WB (15) on mem_done; S_LD_WB -> S_FETCH.
  - Branch: any branch eval state -> S_BR_TAKE (12) if cond_true, else -> S_FETCH; S_BR_TAKE -> S_FETCH.
- Wait counter (wait states are S_FETCH_WAIT, S_LD_WAIT, S_ST_WAIT):
  - Cleared on entry to any wait state.
  - Increments each non-stalled cycle spent in a wait state with mem_done=0, saturating.
  - When it equals MEM_TIMEOUT and mem_done=0, next state is S_TIMEOUT (127).
  - If mem_done=1 in the same cycle the count reaches the limit, mem_done wins and the normal transition is taken.
- Traps:
  - S_ILLEGAL and S_TIMEOUT are sticky and hold until trap_clear=1.
  - trap_clear=1 in a trap state moves to S_FETCH; trap_clear is ignored in all other states.
- stall=1:
  - Holds the state and the counter; has priority over every transition, including trap_clear.
  - Moore outputs keep their current values (mem_req stays asserted).
- Reset mid-sequence (including in a wait state) returns to S_RESET and abandons the request.
- State codes not listed above are unreachable; if one is ever entered, next state is S_ILLEGAL.

Decomposition:
- Package ctrl_seq_pkg holds:
  - all state code localparams, sized STATE_W;
  - opcode and funct constants;
  - the wait-state membership function.
- Sub-module instr_dispatch: combinational casez over instr, returning the dispatch state code.
- control_sequencer itself holds the state register, wait counter, next-state logic and Moore output decode.

Test Plan:
- Reset then fetch:
  - Stimulus: rst_n low then high, mem_done high on the 2nd cycle of S_FETCH_WAIT.
  - Required: state_sel sequence 0,1,2,2,3,4; ir_load=1 and pc_inc=1 only in state 3.
- ADDU dispatch:
  - Stimulus: instr=0x00221821 in S_DECODE.
  - Required: state_sel 6 -> 5 -> 1.
- LW dispatch with stall:
  - Stimulus: instr=0x8C220004; stall held 2 cycles in S_LD_WAIT; mem_done on the 3rd cycle.
  - Required: state_sel 13,14,14,14,15,1; mem_req=1 throughout 14; mem_we=0.
- SW dispatch:
  - Stimulus: instr=0xAC220004, mem_done on the 1st cycle of the wait state.
  - Required: state_sel 7,8,1 with mem_we=1 only in 8.
- BEQ dispatch, both branch outcomes:
  - Stimulus: instr=0x10220003 with cond_true=1, then repeated with cond_true=0.
  - Required: 11 -> 12 -> 1 when taken; 11 -> 1 when not taken.
- Illegal instruction and memory timeout:
  - Stimulus: instr=0xFC000000.
  - Required: state 126 with illegal_trap=1, held until trap_clear, then state 1.
  - Stimulus: mem_done held low in S_FETCH_WAIT with MEM_TIMEOUT=15.
  - Required: state 127 after 16 cycles in the wait state.
  - Stimulus: repeat with mem_done=1 on exactly the 16th wait cycle.
  - Required: state 3.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared state codes, MIPS opcode/funct constants and helpers for the control sequencer.
package ctrl_seq_pkg;

    localparam int unsigned STATE_W = 7;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned RT_W    = 5;

    localparam logic [STATE_W-1:0] S_RESET      = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_FETCH      = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_FETCH_WAIT = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_IR_LOAD    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_DECODE     = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_ALU_WB     = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_ADDU       = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ST_ADDR    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ST_WAIT    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BR_EVAL    = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_BR_TAKE    = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_LD_ADDR    = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_LD_WAIT    = STATE_W'(14);
    localparam logic [STATE_W-1:0] S_LD_WB      = STATE_W'(15);
    localparam logic [STATE_W-1:0] S_SUBU       = STATE_W'(17);
    localparam logic [STATE_W-1:0] S_ADDIU      = STATE_W'(18);
    localparam logic [STATE_W-1:0] S_SLTU       = STATE_W'(19);
    localparam logic [STATE_W-1:0] S_SLTIU      = STATE_W'(20);
    localparam logic [STATE_W-1:0] S_CLO        = STATE_W'(21);
    localparam logic [STATE_W-1:0] S_CLZ        = STATE_W'(22);
    localparam logic [STATE_W-1:0] S_AND        = STATE_W'(23);
    localparam logic [STATE_W-1:0] S_ANDI       = STATE_W'(24);
    localparam logic [STATE_W-1:0] S_OR         = STATE_W'(25);
    localparam logic [STATE_W-1:0] S_ORI        = STATE_W'(26);
    localparam logic [STATE_W-1:0] S_XOR        = STATE_W'(27);
    localparam logic [STATE_W-1:0] S_XORI       = STATE_W'(28);
    localparam logic [STATE_W-1:0] S_NOR        = STATE_W'(29);
    localparam logic [STATE_W-1:0] S_LUI        = STATE_W'(30);
    localparam logic [STATE_W-1:0] S_SLL        = STATE_W'(31);
    localparam logic [STATE_W-1:0] S_SRA        = STATE_W'(32);
    localparam logic [STATE_W-1:0] S_SRL        = STATE_W'(33);
    localparam logic [STATE_W-1:0] S_MOVN       = STATE_W'(34);
    localparam logic [STATE_W-1:0] S_MOVZ       = STATE_W'(35);
    localparam logic [STATE_W-1:0] S_BGEZ       = STATE_W'(37);
    localparam logic [STATE_W-1:0] S_BGTZ       = STATE_W'(39);
    localparam logic [STATE_W-1:0] S_BNE        = STATE_W'(41);
    localparam logic [STATE_W-1:0] S_BLEZ       = STATE_W'(42);
    localparam logic [STATE_W-1:0] S_ILLEGAL    = STATE_W'(126);
    localparam logic [STATE_W-1:0] S_TIMEOUT    = STATE_W'(127);

    localparam logic [OP_W-1:0] OP_SPECIAL  = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_REGIMM   = OP_W'('h01);
    localparam logic [OP_W-1:0] OP_BEQ      = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_BNE      = OP_W'('h05);
    localparam logic [OP_W-1:0] OP_BLEZ     = OP_W'('h06);
    localparam logic [OP_W-1:0] OP_BGTZ     = OP_W'('h07);
    localparam logic [OP_W-1:0] OP_ADDIU    = OP_W'('h09);
    localparam logic [OP_W-1:0] OP_SLTIU    = OP_W'('h0B);
    localparam logic [OP_W-1:0] OP_ANDI     = OP_W'('h0C);
    localparam logic [OP_W-1:0] OP_ORI      = OP_W'('h0D);
    localparam logic [OP_W-1:0] OP_XORI     = OP_W'('h0E);
    localparam logic [OP_W-1:0] OP_LUI      = OP_W'('h0F);
    localparam logic [OP_W-1:0] OP_SPECIAL2 = OP_W'('h1C);
    localparam logic [OP_W-1:0] OP_LB       = OP_W'('h20);
    localparam logic [OP_W-1:0] OP_LH       = OP_W'('h21);
    localparam logic [OP_W-1:0] OP_LW       = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_LBU      = OP_W'('h24);
    localparam logic [OP_W-1:0] OP_LHU      = OP_W'('h25);
    localparam logic [OP_W-1:0] OP_SB       = OP_W'('h28);
    localparam logic [OP_W-1:0] OP_SH       = OP_W'('h29);
    localparam logic [OP_W-1:0] OP_SW       = OP_W'('h2B);

    localparam logic [FN_W-1:0] F_SLL  = FN_W'('h00);
    localparam logic [FN_W-1:0] F_SRL  = FN_W'('h02);
    localparam logic [FN_W-1:0] F_SRA  = FN_W'('h03);
    localparam logic [FN_W-1:0] F_MOVZ = FN_W'('h0A);
    localparam logic [FN_W-1:0] F_MOVN = FN_W'('h0B);
    localparam logic [FN_W-1:0] F_ADDU = FN_W'('h21);
    localparam logic [FN_W-1:0] F_SUBU = FN_W'('h23);
    localparam logic [FN_W-1:0] F_AND  = FN_W'('h24);
    localparam logic [FN_W-1:0] F_OR   = FN_W'('h25);
    localparam logic [FN_W-1:0] F_XOR  = FN_W'('h26);
    localparam logic [FN_W-1:0] F_NOR  = FN_W'('h27);
    localparam logic [FN_W-1:0] F_SLTU = FN_W'('h2B);
    localparam logic [FN_W-1:0] F_CLZ  = FN_W'('h20);
    localparam logic [FN_W-1:0] F_CLO  = FN_W'('h21);

    localparam logic [RT_W-1:0] RT_BGEZ = RT_W'('h01);

    // States that hold a memory request open and run the timeout counter
    function automatic logic is_wait_state(input logic [STATE_W-1:0] s);
        return (s == S_FETCH_WAIT) || (s == S_LD_WAIT) || (s == S_ST_WAIT);
    endfunction

endpackage

// File: rtl/control_sequencer_dispatch.sv
// Instruction decode: maps an instruction word to the first execute state code.
module instr_dispatch
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned IR_W = 32
) (
    input  logic [IR_W-1:0]    instr,
    output logic [STATE_W-1:0] dispatch_c
);

    logic [OP_W-1:0] opcode;
    logic [RT_W-1:0] rt;
    logic [FN_W-1:0] funct;
    logic            unused_fields;

    assign opcode        = instr[IR_W-1 -: OP_W];
    assign rt            = instr[20:16];
    assign funct         = instr[FN_W-1:0];
    assign unused_fields = ^{instr[IR_W-OP_W-1:21], instr[15:FN_W]};

    always_comb begin
        dispatch_c = S_ILLEGAL;
        casez (opcode)
            OP_SPECIAL: begin
                case (funct)
                    F_ADDU:  dispatch_c = S_ADDU;
                    F_SUBU:  dispatch_c = S_SUBU;
                    F_SLTU:  dispatch_c = S_SLTU;
                    F_AND:   dispatch_c = S_AND;
                    F_OR:    dispatch_c = S_OR;
                    F_XOR:   dispatch_c = S_XOR;
                    F_NOR:   dispatch_c = S_NOR;
                    F_SLL:   dispatch_c = S_SLL;
                    F_SRA:   dispatch_c = S_SRA;
                    F_SRL:   dispatch_c = S_SRL;
                    F_MOVN:  dispatch_c = S_MOVN;
                    F_MOVZ:  dispatch_c = S_MOVZ;
                    default: dispatch_c = S_ILLEGAL;
                endcase
            end
            OP_SPECIAL2: begin
                case (funct)
                    F_CLO:   dispatch_c = S_CLO;
                    F_CLZ:   dispatch_c = S_CLZ;
                    default: dispatch_c = S_ILLEGAL;
                endcase
            end
            // BGEZ lives in the REGIMM space, selected by the rt field
            OP_REGIMM: dispatch_c = (rt == RT_BGEZ) ? S_BGEZ : S_ILLEGAL;
            OP_ADDIU:  dispatch_c = S_ADDIU;
            OP_SLTIU:  dispatch_c = S_SLTIU;
            OP_ANDI:   dispatch_c = S_ANDI;
            OP_ORI:    dispatch_c = S_ORI;
            OP_XORI:   dispatch_c = S_XORI;
            OP_LUI:    dispatch_c = S_LUI;
            OP_SB, OP_SH, OP_SW: dispatch_c = S_ST_ADDR;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: dispatch_c = S_LD_ADDR;
            OP_BEQ:    dispatch_c = S_BR_EVAL;
            OP_BNE:    dispatch_c = S_BNE;
            OP_BGTZ:   dispatch_c = S_BGTZ;
            OP_BLEZ:   dispatch_c = S_BLEZ;
            default:   dispatch_c = S_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle MIPS control sequencer: fetch/decode/execute stepping, memory wait timeout, sticky traps.
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned IR_W        = 32,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned WAIT_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IR_W-1:0]    instr,
    input  logic               mem_done,
    input  logic               cond_true,
    input  logic               stall,
    input  logic               trap_clear,
    output logic [STATE_W-1:0] state_sel,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               illegal_trap,
    output logic               timeout_trap
);

    logic [STATE_W-1:0] state, state_nxt, dispatch_c;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic               timeout_hit_c;
    logic               mem_req_nxt, mem_we_nxt, ir_load_nxt, illegal_nxt, timeout_nxt;

    instr_dispatch #(.IR_W(IR_W)) u_dispatch (
        .instr      (instr),
        .dispatch_c (dispatch_c)
    );

    // mem_done takes priority over an expiring counter
    assign timeout_hit_c = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT)) && !mem_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RESET;
            wait_cnt     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            ir_load      <= 1'b0;
            pc_inc       <= 1'b0;
            illegal_trap <= 1'b0;
            timeout_trap <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            mem_req      <= mem_req_nxt;
            mem_we       <= mem_we_nxt;
            ir_load      <= ir_load_nxt;
            pc_inc       <= ir_load_nxt;
            illegal_trap <= illegal_nxt;
            timeout_trap <= timeout_nxt;
        end
    end

    assign state_sel = state;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        if (!stall) begin
            if (is_wait_state(state) && !mem_done) begin
                wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_W'(1);
            end else begin
                wait_nxt = '0;
            end
            case (state)
                S_RESET:      state_nxt = S_FETCH;
                S_FETCH:      state_nxt = S_FETCH_WAIT;
                S_FETCH_WAIT: state_nxt = mem_done ? S_IR_LOAD : (timeout_hit_c ? S_TIMEOUT : state);
                S_IR_LOAD:    state_nxt = S_DECODE;
                S_DECODE:     state_nxt = dispatch_c;
                S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ, S_AND, S_ANDI, S_OR,
                S_ORI, S_XOR, S_XORI, S_NOR, S_LUI, S_SLL, S_SRA, S_SRL, S_MOVN, S_MOVZ:
                              state_nxt = S_ALU_WB;
                S_ALU_WB:     state_nxt = S_FETCH;
                S_ST_ADDR:    state_nxt = S_ST_WAIT;
                S_ST_WAIT:    state_nxt = mem_done ? S_FETCH : (timeout_hit_c ? S_TIMEOUT : state);
                S_LD_ADDR:    state_nxt = S_LD_WAIT;
                S_LD_WAIT:    state_nxt = mem_done ? S_LD_WB : (timeout_hit_c ? S_TIMEOUT : state);
                S_LD_WB:      state_nxt = S_FETCH;
                S_BR_EVAL, S_BNE, S_BGEZ, S_BGTZ, S_BLEZ:
                              state_nxt = cond_true ? S_BR_TAKE : S_FETCH;
                S_BR_TAKE:    state_nxt = S_FETCH;
                S_ILLEGAL, S_TIMEOUT:
                              state_nxt = trap_clear ? S_FETCH : state;
                default:      state_nxt = S_ILLEGAL;
            endcase
        end

        // Outputs are decoded from the next state so they register in step with state_sel
        mem_req_nxt = is_wait_state(state_nxt) || (state_nxt == S_FETCH);
        mem_we_nxt  = (state_nxt == S_ST_WAIT);
        ir_load_nxt = (state_nxt == S_IR_LOAD);
        illegal_nxt = (state_nxt == S_ILLEGAL);
        timeout_nxt = (state_nxt == S_TIMEOUT);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed walkthrough plus randomized run against a table-driven reference model.
module tb_control_sequencer;

    localparam int unsigned IR_W        = 32;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned WAIT_W      = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_done = 1'b0;
    logic        cond_true = 1'b0;
    logic        stall = 1'b0;
    logic        trap_clear = 1'b0;
    logic [6:0]  state_sel;
    logic        mem_req, mem_we, ir_load, pc_inc, illegal_trap, timeout_trap;

    int n_checks = 0;
    int n_errors = 0;
    int exp_state = 0;
    int waited = 0;

    // Decode reference tables: R-type funct, I-type opcode, SPECIAL2 funct
    int r_fn[12]  = '{'h21, 'h23, 'h2B, 'h24, 'h25, 'h26, 'h27, 'h00, 'h03, 'h02, 'h0B, 'h0A};
    int r_st[12]  = '{6,    17,   19,   23,   25,   27,   29,   31,   32,   33,   34,   35};
    int i_op[18]  = '{'h09, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h28, 'h29, 'h2B,
                      'h20, 'h21, 'h23, 'h24, 'h25, 'h04, 'h05, 'h06, 'h07};
    int i_st[18]  = '{18,   20,   24,   26,   28,   30,   7,    7,    7,
                      13,   13,   13,   13,   13,   11,   41,   42,   39};
    int s2_fn[2]  = '{'h21, 'h20};
    int s2_st[2]  = '{21,   22};

    always #5 clk = ~clk;

    control_sequencer #(
        .IR_W        (IR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .WAIT_W      (WAIT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .mem_done     (mem_done),
        .cond_true    (cond_true),
        .stall        (stall),
        .trap_clear   (trap_clear),
        .state_sel    (state_sel),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_load      (ir_load),
        .pc_inc       (pc_inc),
        .illegal_trap (illegal_trap),
        .timeout_trap (timeout_trap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_dispatch(input logic [31:0] w);
        int op;
        int fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        if (op == 0) begin
            for (int i = 0; i < 12; i++) if (fn == r_fn[i]) return r_st[i];
            return 126;
        end
        if (op == 'h1C) begin
            for (int i = 0; i < 2; i++) if (fn == s2_fn[i]) return s2_st[i];
            return 126;
        end
        if (op == 1) return (w[20:16] == 5'd1) ? 37 : 126;
        for (int i = 0; i < 18; i++) if (op == i_op[i]) return i_st[i];
        return 126;
    endfunction

    // {mem_req, mem_we, ir_load, pc_inc, illegal_trap, timeout_trap}
    function automatic logic [5:0] ref_outs(input int s);
        logic [5:0] o;
        o[5] = (s == 1) || (s == 2) || (s == 8) || (s == 14);
        o[4] = (s == 8);
        o[3] = (s == 3);
        o[2] = (s == 3);
        o[1] = (s == 126);
        o[0] = (s == 127);
        return o;
    endfunction

    task automatic ref_step();
        int nxt;
        bit in_wait;
        if (stall) return;
        in_wait = (exp_state == 2) || (exp_state == 8) || (exp_state == 14);
        nxt = exp_state;
        if (exp_state == 126 || exp_state == 127) begin
            if (trap_clear) nxt = 1;
        end else if (in_wait) begin
            if (mem_done) nxt = (exp_state == 2) ? 3 : ((exp_state == 8) ? 1 : 15);
            else if (MEM_TIMEOUT != 0 && waited == int'(MEM_TIMEOUT)) nxt = 127;
        end else if (exp_state == 4) begin
            nxt = ref_dispatch(instr);
        end else if (exp_state == 6 || (exp_state >= 17 && exp_state <= 35)) begin
            nxt = 5;
        end else if (exp_state == 11 || exp_state == 37 || exp_state == 39 ||
                     exp_state == 41 || exp_state == 42) begin
            nxt = cond_true ? 12 : 1;
        end else begin
            case (exp_state)
                0:       nxt = 1;
                1:       nxt = 2;
                3:       nxt = 4;
                5:       nxt = 1;
                7:       nxt = 8;
                12:      nxt = 1;
                13:      nxt = 14;
                15:      nxt = 1;
                default: nxt = 126;
            endcase
        end
        waited = (in_wait && !mem_done) ? waited + 1 : 0;
        exp_state = nxt;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        ref_step();
        #1;
        check({tag, ".state"}, 32'(state_sel), 32'(exp_state));
        check({tag, ".outs"}, 32'({mem_req, mem_we, ir_load, pc_inc, illegal_trap, timeout_trap}),
              32'(ref_outs(exp_state)));
    endtask

    task automatic step(input string tag, input int exp_sel);
        tick(tag);
        check({tag, ".seq"}, 32'(state_sel), 32'(exp_sel));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset.state", 32'(state_sel), 32'd0);
        check("reset.outs", 32'({mem_req, mem_we, ir_load, pc_inc, illegal_trap, timeout_trap}), 32'd0);
        exp_state = 0;
        waited = 0;
        mem_done = 1'b0;
        stall = 1'b0;
        trap_clear = 1'b0;
        cond_true = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fetch_to_decode(input logic [31:0] w);
        mem_done = 1'b1;
        step("fetch", 2);
        step("fetch", 3);
        mem_done = 1'b0;
        step("fetch", 4);
        instr = w;
    endtask

    initial begin
        logic [31:0] w;
        int md_prob;

        do_reset();

        // Reset then fetch: mem_done on the second wait cycle
        instr = 32'h0022_1821;
        step("rf", 1);
        step("rf", 2);
        step("rf", 2);
        mem_done = 1'b1;
        step("rf", 3);
        check("rf.ir_load", 32'(ir_load), 32'd1);
        check("rf.pc_inc", 32'(pc_inc), 32'd1);
        mem_done = 1'b0;
        step("rf", 4);

        step("addu", 6);
        step("addu", 5);
        step("addu", 1);

        fetch_to_decode(32'h8C22_0004);
        step("lw", 13);
        step("lw", 14);
        stall = 1'b1;
        step("lw.stall", 14);
        step("lw.stall", 14);
        check("lw.mem_req", 32'(mem_req), 32'd1);
        check("lw.mem_we", 32'(mem_we), 32'd0);
        stall = 1'b0;
        mem_done = 1'b1;
        step("lw", 15);
        mem_done = 1'b0;
        step("lw", 1);

        fetch_to_decode(32'hAC22_0004);
        step("sw", 7);
        step("sw", 8);
        check("sw.mem_we", 32'(mem_we), 32'd1);
        mem_done = 1'b1;
        step("sw", 1);
        mem_done = 1'b0;

        fetch_to_decode(32'h1022_0003);
        cond_true = 1'b1;
        step("beq.t", 11);
        step("beq.t", 12);
        step("beq.t", 1);
        fetch_to_decode(32'h1022_0003);
        cond_true = 1'b0;
        step("beq.nt", 11);
        step("beq.nt", 1);

        fetch_to_decode(32'hFC00_0000);
        step("ill", 126);
        check("ill.trap", 32'(illegal_trap), 32'd1);
        step("ill.hold", 126);
        stall = 1'b1;
        trap_clear = 1'b1;
        step("ill.stall", 126);
        stall = 1'b0;
        step("ill.clear", 1);
        trap_clear = 1'b0;

        // Timeout: 16 wait cycles without mem_done
        step("tmo", 2);
        for (int i = 0; i < 15; i++) step("tmo.wait", 2);
        step("tmo", 127);
        check("tmo.trap", 32'(timeout_trap), 32'd1);
        trap_clear = 1'b1;
        step("tmo.clear", 1);
        trap_clear = 1'b0;

        // mem_done on exactly the 16th wait cycle wins over the timeout
        step("edge", 2);
        for (int i = 0; i < 15; i++) step("edge.wait", 2);
        mem_done = 1'b1;
        step("edge", 3);
        mem_done = 1'b0;
        step("edge", 4);

        // Reset while a request is outstanding
        instr = 32'h0022_1821;
        step("mid", 6);
        step("mid", 5);
        step("mid", 1);
        step("mid", 2);
        do_reset();

        md_prob = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0:       md_prob = 0;
                    1:       md_prob = 30;
                    default: md_prob = 90;
                endcase
            end
            w = $urandom;
            case ($urandom_range(0, 4))
                0: begin
                    w[31:26] = 6'h00;
                    w[5:0] = 6'(r_fn[$urandom_range(0, 11)]);
                end
                1, 2: w[31:26] = 6'(i_op[$urandom_range(0, 17)]);
                3: begin
                    if ($urandom_range(0, 1) == 0) begin
                        w[31:26] = 6'h1C;
                        w[5:0] = 6'(s2_fn[$urandom_range(0, 1)]);
                    end else begin
                        w[31:26] = 6'h01;
                        if ($urandom_range(0, 3) != 0) w[20:16] = 5'd1;
                    end
                end
                default: ;
            endcase
            instr = w;
            mem_done = ($urandom_range(0, 99) < md_prob);
            cond_true = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 7) == 0);
            trap_clear = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
